// File: rtl/ctrl_pkg.sv
// Shared encodings for the controller, ALU and immediate generator.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_R = 2'b11
  } imm_e;

  // funct3/funct7[5] to ALU operation; SUB exists only for register-register ops
  function automatic aluop_e alu_fn(input logic [2:0] f3, input logic f7b5, input logic is_r);
    aluop_e op;
    case (f3)
      3'b000:  if (is_r && f7b5) op = ALU_SUB; else op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  if (f7b5) op = ALU_SRA; else op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface ctrl_fsm_if;
  logic [31:0] instr;
  logic [4:0]  status;
  logic        mem_ready;
  logic        pcsrc;
  logic        alusrc;
  logic [3:0]  aluop;
  logic        mrw;
  logic        wb;
  logic        regrw;
  logic [1:0]  immgen_ctrl;
  logic        pc_en;
  logic        mem_req;
  logic [2:0]  state;
  logic        trap;

  modport master (
    input  instr, status, mem_ready,
    output pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl, pc_en, mem_req, state, trap
  );

  modport slave (
    output instr, status, mem_ready,
    input  pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl, pc_en, mem_req, state, trap
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct fields to ALU/immediate controls,
// instruction class, legality and branch-taken evaluation.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [3:0] flags_i,
  output aluop_e     aluop_o,
  output imm_e       immgen_o,
  output logic       alusrc_o,
  output logic       legal_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       br_take_o
);

  logic lt;
  assign lt = flags_i[1] ^ flags_i[3];

  // decode table; anything not listed stays illegal with zeroed controls
  always_comb begin
    aluop_o     = ALU_ADD;
    immgen_o    = IMM_I;
    alusrc_o    = 1'b0;
    legal_o     = 1'b0;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    is_branch_o = 1'b0;
    br_take_o   = 1'b0;
    case (opcode_i)
      OP_R_ALU: begin
        legal_o  = 1'b1;
        aluop_o  = alu_fn(funct3_i, funct7b5_i, 1'b1);
        immgen_o = IMM_R;
      end
      OP_I_ALU: begin
        legal_o  = 1'b1;
        aluop_o  = alu_fn(funct3_i, funct7b5_i, 1'b0);
        alusrc_o = 1'b1;
      end
      OP_LOAD: begin
        legal_o   = 1'b1;
        alusrc_o  = 1'b1;
        is_load_o = 1'b1;
      end
      OP_STORE: begin
        legal_o    = 1'b1;
        alusrc_o   = 1'b1;
        immgen_o   = IMM_S;
        is_store_o = 1'b1;
      end
      OP_BRANCH: begin
        aluop_o     = ALU_SUB;
        immgen_o    = IMM_B;
        is_branch_o = 1'b1;
        case (funct3_i)
          3'b000:  begin legal_o = 1'b1; br_take_o = flags_i[0];  end
          3'b001:  begin legal_o = 1'b1; br_take_o = !flags_i[0]; end
          3'b100:  begin legal_o = 1'b1; br_take_o = lt;          end
          3'b101:  begin legal_o = 1'b1; br_take_o = !lt;         end
          default: legal_o = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle CPU control FSM: state register, instruction register and optional
// MEM-wait timeout (enabled by defining CTRL_FSM_MEM_TIMEOUT_EN).
//
// state  | meaning
// FETCH  | instruction word presented; captured into ir_q on exit
// DECODE | classify ir_q; illegal encodings go to TRAP
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | RAM access, held until mem_ready (or timeout)
// WB     | register write-back; retires ALU ops and loads
// TRAP   | sticky error state, left only by reset
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  ctrl_fsm_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;

  aluop_e dec_aluop;
  imm_e   dec_imm;
  logic   dec_alusrc, dec_legal, dec_load, dec_store, dec_branch, dec_take;
  logic   dec_en;
  logic   unused_bits;

  assign unused_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7], bus.status[4]};

  ctrl_decode u_decode (
    .opcode_i    (ir_q[6:0]),
    .funct3_i    (ir_q[14:12]),
    .funct7b5_i  (ir_q[30]),
    .flags_i     (bus.status[3:0]),
    .aluop_o     (dec_aluop),
    .immgen_o    (dec_imm),
    .alusrc_o    (dec_alusrc),
    .legal_o     (dec_legal),
    .is_load_o   (dec_load),
    .is_store_o  (dec_store),
    .is_branch_o (dec_branch),
    .br_take_o   (dec_take)
  );

`ifdef CTRL_FSM_MEM_TIMEOUT_EN
  logic [3:0] tmo_q, tmo_d;
  logic       tmo_hit;

  assign tmo_hit = (state_q == ST_MEM) && !bus.mem_ready && (tmo_q == 4'd15);

  // counter sits at zero outside MEM, so every MEM visit starts from zero
  always_comb begin
    tmo_d = 4'd0;
    if (state_q == ST_MEM && !bus.mem_ready) tmo_d = tmo_q + 4'd1;
  end

  // timeout counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= 4'd0;
    else        tmo_q <= tmo_d;
  end
`endif

  // state and instruction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) ir_q <= bus.instr;
    end
  end

  assign bus.state = state_q;

  // next state and control outputs; outputs are zero unless a state asserts them
  always_comb begin
    state_d         = state_q;
    dec_en          = 1'b0;
    bus.pcsrc       = 1'b0;
    bus.alusrc      = 1'b0;
    bus.aluop       = 4'd0;
    bus.mrw         = 1'b0;
    bus.wb          = 1'b0;
    bus.regrw       = 1'b0;
    bus.immgen_ctrl = 2'b00;
    bus.pc_en       = 1'b0;
    bus.mem_req     = 1'b0;
    bus.trap        = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        dec_en  = dec_legal;
        state_d = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        dec_en = 1'b1;
        if (dec_branch) begin
          bus.pc_en = 1'b1;
          bus.pcsrc = dec_take;
          state_d   = ST_FETCH;
        end else if (dec_load || dec_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dec_en      = 1'b1;
        bus.mem_req = 1'b1;
        bus.mrw     = dec_store;
        if (bus.mem_ready) begin
          bus.pc_en = dec_store;
          state_d   = dec_store ? ST_FETCH : ST_WB;
        end
`ifdef CTRL_FSM_MEM_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ST_TRAP;
        end
`endif
      end
      ST_WB: begin
        dec_en    = 1'b1;
        bus.regrw = 1'b1;
        bus.wb    = dec_load;
        bus.pc_en = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: bus.trap = 1'b1;
      default: state_d = ST_FETCH;
    endcase
    if (dec_en) begin
      bus.aluop       = dec_aluop;
      bus.alusrc      = dec_alusrc;
      bus.immgen_ctrl = dec_imm;
    end
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port instr, input, 32, fetched instruction word from the datapath.
REQ-004 SHALL have port status, input, 5, ALU flags: [0] zero, [1] negative, [2] carry, [3] overflow, [4] reserved.
REQ-005 SHALL have port mem_ready, input, 1, RAM access complete (handshake).
REQ-006 SHALL have outputs pcsrc (1), alusrc (1), aluop (4), mrw (1, 1=write), wb (1, 1=RAM data to regfile), regrw (1), immgen_ctrl (2), pc_en (1), mem_req (1), state (3), trap (1).

Function
REQ-007 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-008 SHALL capture instr into an internal instruction register on the FETCH->DECODE edge; all decode SHALL use the register, not the live port.
REQ-009 SHALL decode opcode instr[6:0]: 0110011 R-ALU, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch; any other opcode is illegal.
REQ-010 SHALL map aluop: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, from funct3/funct7[5]; SUB/SRA only on funct7[5]=1 (SUB for R-type only).
REQ-011 SHALL drive aluop=ADD for load/store, SUB for branch.
REQ-012 SHALL drive immgen_ctrl 00 I-type, 01 S-type, 10 B-type, 11 R-type; alusrc=1 for I-ALU/load/store, else 0.
REQ-013 Transitions: FETCH->DECODE always; DECODE->EXEC if legal else TRAP; EXEC->WB for ALU ops, ->MEM for load/store, ->FETCH for branch; MEM->MEM while mem_ready=0, on mem_ready=1 store->FETCH, load->WB; WB->FETCH; TRAP->TRAP until reset.
REQ-014 mem_req SHALL be 1 in every MEM cycle; mrw=1 only in MEM for store.
REQ-015 regrw SHALL be 1 for exactly the single WB cycle; wb=1 in WB for load, else 0.
REQ-016 pc_en SHALL pulse 1 for one cycle in the final state of each instruction (WB, MEM-with-store-and-mem_ready, EXEC-branch); never in TRAP.
REQ-017 Branch take: funct3 000 status[0]; 001 !status[0]; 100 status[1]^status[3]; 101 !(status[1]^status[3]); other funct3 illegal (DECODE->TRAP).
REQ-018 pcsrc SHALL be 1 only in the EXEC cycle of a taken branch, coincident with pc_en.
REQ-019 trap SHALL be 1 in TRAP, 0 elsewhere; state output SHALL equal the state encoding.
REQ-020 All outputs not asserted by the rules above SHALL be 0.

Reset
REQ-021 reset=0 SHALL asynchronously force state FETCH, instruction register 0, all outputs 0 (state=0), timeout counter 0.
REQ-022 Reset asserted mid-MEM SHALL abort the access; mem_req drops asynchronously.

Configuration
REQ-023 With CTRL_FSM_MEM_TIMEOUT_EN defined, a 4-bit counter SHALL count MEM cycles with mem_ready=0 and enter TRAP when 16 such cycles elapse; counter clears on MEM entry.
REQ-024 Without CTRL_FSM_MEM_TIMEOUT_EN, MEM SHALL wait indefinitely and no counter SHALL exist.

Structure
REQ-025 State encodings, opcode constants, aluop and immgen_ctrl encodings SHALL live in shared package ctrl_pkg, reused by the ALU and ImmGen.
REQ-026 Combinational decode (opcode/funct -> aluop, immgen_ctrl, alusrc, legal, branch condition) SHALL be sub-module ctrl_decode; ctrl_fsm holds state, instruction register, counter.

Verification
REQ-027 ADD x3,x1,x2 (0x002081B3) -> states 0,1,2,4,0; aluop=0000, alusrc=0, regrw=1 and pc_en=1 only in WB cycle.
REQ-028 LW with mem_ready low 3 cycles -> MEM held 4 cycles, mem_req=1, mrw=0, then WB with wb=1, regrw=1.
REQ-029 BEQ with status[0]=1 -> EXEC cycle pcsrc=1, pc_en=1, aluop=0001, immgen_ctrl=10; status[0]=0 -> pcsrc=0, pc_en=1.
REQ-030 instr=0xFFFFFFFF -> DECODE->TRAP, trap=1 held, pc_en=0 until reset=0.
REQ-031 SW with mem_ready never asserted -> with CTRL_FSM_MEM_TIMEOUT_EN, TRAP after 16 MEM cycles; without, remains in MEM.
REQ-032 reset=0 asserted mid-MEM of store -> same-cycle state=0, mem_req=0, mrw=0; after release, normal fetch resumes.
